// File: rtl/serial_master.sv
// rtl/serial_master.sv - byte-wide LSB-first serial master driving SCK/MOSI and capturing MISO
module serial_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] sendData,
  output logic [7:0] receivedData,
  output logic       busy,
  output logic       done,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO
);

  generate
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $error("serial_master: HALF_PERIOD must be >= 1");
    end
  endgenerate

  localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [HC_W-1:0] half_cnt, half_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [7:0]      tx_shift, tx_nxt;
  logic [7:0]      rx_shift, rx_nxt;
  logic [7:0]      rd_q, rd_nxt;
  logic            sck_q, sck_nxt;
  logic            mosi_q, mosi_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            half_done;

  assign half_done    = (half_cnt == HC_LAST);
  assign receivedData = rd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign SCK          = sck_q;
  assign MOSI         = mosi_q;

  // State and output registers; reset returns everything to idle values at once.
  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rd_q     <= '0;
      sck_q    <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      half_cnt <= half_nxt;
      bit_cnt  <= bit_nxt;
      tx_shift <= tx_nxt;
      rx_shift <= rx_nxt;
      rd_q     <= rd_nxt;
      sck_q    <= sck_nxt;
      mosi_q   <= mosi_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next-state logic: one SCK low/high pair per bit; the last high half-period is the guard.
  always_comb begin
    state_nxt = state;
    half_nxt  = half_cnt;
    bit_nxt   = bit_cnt;
    tx_nxt    = tx_shift;
    rx_nxt    = rx_shift;
    rd_nxt    = rd_q;
    sck_nxt   = sck_q;
    mosi_nxt  = mosi_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        sck_nxt  = 1'b1;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          tx_nxt    = sendData;
          mosi_nxt  = sendData[0];
          sck_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          bit_nxt   = 3'd0;
          half_nxt  = '0;
          state_nxt = LOW;
        end
      end

      LOW: begin
        if (half_done) begin
          // MISO has been stable for a full low half-period when SCK rises.
          half_nxt  = '0;
          sck_nxt   = 1'b1;
          rx_nxt    = {MISO, rx_shift[7:1]};
          state_nxt = (bit_cnt == 3'd7) ? GUARD : HIGH;
        end else begin
          half_nxt = half_cnt + 1'b1;
        end
      end

      HIGH: begin
        if (half_done) begin
          half_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = GUARD;
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            sck_nxt   = 1'b0;
            mosi_nxt  = tx_shift[bit_cnt + 3'd1];
            state_nxt = LOW;
          end
        end else begin
          half_nxt = half_cnt + 1'b1;
        end
      end

      GUARD: begin
        if (half_done) begin
          half_nxt  = '0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          rd_nxt    = rx_shift;
          mosi_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          half_nxt = half_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_master.sv
// tb/tb_serial_master.sv - self-checking bench for serial_master (H=4 and H=1 instances)
module tb_serial_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res4, start4, sck4, mosi4, busy4, done4, miso4;
  logic [7:0] data4, rd4;
  logic       res1, start1, sck1, mosi1, busy1, done1, miso1;
  logic [7:0] data1, rd1;

  logic       slave_mode;
  logic       slave_txd;
  logic [7:0] slave_pre, slave_sh, slave_rx;
  int         slave_cnt;
  logic       slave_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int fall4 = 0;
  int rise4 = 0;

  assign miso4 = slave_mode ? slave_txd : mosi4;
  assign miso1 = mosi1;

  serial_master #(.HALF_PERIOD(4)) u_h4 (
    .clk(clk), .res(res4), .start(start4), .sendData(data4),
    .receivedData(rd4), .busy(busy4), .done(done4),
    .SCK(sck4), .MOSI(mosi4), .MISO(miso4)
  );

  serial_master #(.HALF_PERIOD(1)) u_h1 (
    .clk(clk), .res(res1), .start(start1), .sendData(data1),
    .receivedData(rd1), .busy(busy1), .done(done1),
    .SCK(sck1), .MOSI(mosi1), .MISO(miso1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edge counters on the H=4 serial clock.
  always @(negedge sck4) fall4++;
  always @(posedge sck4) rise4++;

  // Behavioural slave: loads its byte on the first falling edge, samples RXD on rising edges.
  always @(negedge sck4) begin
    if (slave_mode) begin
      if (slave_cnt == 0) slave_sh = slave_pre;
      slave_txd = slave_sh[slave_cnt];
    end
  end
  always @(posedge sck4) begin
    if (slave_mode) begin
      slave_rx[slave_cnt] = mosi4;
      if (slave_cnt == 7) begin
        slave_cnt  = 0;
        slave_flag = 1'b1;
      end else begin
        slave_cnt++;
      end
    end
  end

  task automatic slave_reset();
    slave_cnt  = 0;
    slave_flag = 1'b0;
    slave_rx   = 8'h00;
    slave_txd  = 1'b0;
  endtask

  // Timeline model: n = cycles since the start-accepting edge (0 = idle).
  int         hp   [2] = '{4, 1};
  int         n_m  [2] = '{0, 0};
  logic [7:0] b_m  [2];
  logic [7:0] acc_m[2];
  logic [7:0] rd_m [2];
  bit         ok_m [2] = '{0, 0};

  always @(negedge clk) begin : cmp
    int   h, n, p;
    logic e_sck, e_mosi, e_busy, e_done;
    logic a_sck, a_mosi, a_busy, a_done, v_res, v_start, v_miso;
    logic [7:0] a_rd, v_data;
    for (int d = 0; d < 2; d++) begin
      h = hp[d];
      n = n_m[d];
      a_sck   = (d == 0) ? sck4   : sck1;
      a_mosi  = (d == 0) ? mosi4  : mosi1;
      a_busy  = (d == 0) ? busy4  : busy1;
      a_done  = (d == 0) ? done4  : done1;
      a_rd    = (d == 0) ? rd4    : rd1;
      v_res   = (d == 0) ? res4   : res1;
      v_start = (d == 0) ? start4 : start1;
      v_data  = (d == 0) ? data4  : data1;
      v_miso  = (d == 0) ? miso4  : miso1;
      if (ok_m[d]) begin
        if (n >= 1 && n <= 16 * h) begin
          p      = (n - 1) / h;
          e_sck  = (p % 2) == 1;
          e_mosi = b_m[d][(n - 1) / (2 * h)];
          e_busy = 1'b1;
          e_done = 1'b0;
        end else begin
          e_sck  = 1'b1;
          e_mosi = 1'b0;
          e_busy = 1'b0;
          e_done = (n == 16 * h + 1);
        end
        check($sformatf("sck[%0d]", d),  a_sck,  e_sck);
        check($sformatf("mosi[%0d]", d), a_mosi, e_mosi);
        check($sformatf("busy[%0d]", d), a_busy, e_busy);
        check($sformatf("done[%0d]", d), a_done, e_done);
        check($sformatf("rd[%0d]", d),   a_rd,   rd_m[d]);
      end
      if (v_res) begin
        n_m[d]  = 0;
        rd_m[d] = 8'h00;
        ok_m[d] = 1'b1;
      end else if (ok_m[d]) begin
        if ((n == 0 || n == 16 * h + 1) && v_start) begin
          n_m[d]   = 1;
          b_m[d]   = v_data;
          acc_m[d] = 8'h00;
        end else if (n >= 1 && n <= 16 * h) begin
          if ((n % h) == 0 && ((n / h) % 2) == 1) acc_m[d][n / (2 * h)] = v_miso;
          n_m[d] = n + 1;
          if (n_m[d] == 16 * h + 1) rd_m[d] = acc_m[d];
        end else begin
          n_m[d] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int sel, input logic [7:0] v);
    if (sel == 0) begin start4 = 1'b1; data4 = v; end
    else          begin start1 = 1'b1; data1 = v; end
    tick();
    start4 = 1'b0;
    start1 = 1'b0;
  endtask

  // Returns the cycle (relative to the accepting edge) on which done is seen.
  task automatic wait_done(input int sel, input int c0, output int cyc, output int busy_cycles);
    cyc = c0;
    busy_cycles = 0;
    while (((sel == 0) ? done4 : done1) !== 1'b1 && cyc < 300) begin
      if (((sel == 0) ? busy4 : busy1) === 1'b1) busy_cycles++;
      tick();
      cyc++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc, bc, dones;
    res4 = 1'b1; res1 = 1'b1; start4 = 1'b0; start1 = 1'b0;
    data4 = 8'h00; data1 = 8'h00; slave_mode = 1'b0; slave_pre = 8'h00;
    slave_sh = 8'h00;
    slave_reset();
    repeat (3) tick();
    res4 = 1'b0; res1 = 1'b0;
    check("reset_sck", sck4, 1'b1);
    check("reset_rd", rd4, 8'h00);
    tick();

    // Loopback A5, H=4
    fall4 = 0; rise4 = 0;
    go(0, 8'hA5);
    wait_done(0, 1, cyc, bc);
    check("t2_done_cycle", cyc, 65);
    check("t2_busy_cycles", bc, 64);
    check("t2_rd", rd4, 8'hA5);
    check("t2_busy_on_done", busy4, 1'b0);
    repeat (6) tick();
    check("t2_falls", fall4, 8);
    check("t2_rises", rise4, 8);

    // Reset mid-activity for 3 cycles
    go(0, 8'h3C);
    repeat (10) tick();
    res4 = 1'b1;
    repeat (3) tick();
    check("t1_sck", sck4, 1'b1);
    check("t1_mosi", mosi4, 1'b0);
    check("t1_busy", busy4, 1'b0);
    check("t1_done", done4, 1'b0);
    check("t1_rd", rd4, 8'h00);
    res4 = 1'b0;
    tick();

    // Slave model preloaded with 3C, master sends C3
    slave_reset();
    slave_pre = 8'h3C;
    slave_mode = 1'b1;
    go(0, 8'hC3);
    check("t3_flag_early", slave_flag, 1'b0);
    wait_done(0, 1, cyc, bc);
    check("t3_done_cycle", cyc, 65);
    check("t3_rd", rd4, 8'h3C);
    check("t3_slave_rx", slave_rx, 8'hC3);
    check("t3_slave_flag", slave_flag, 1'b1);
    tick();
    slave_mode = 1'b0;
    tick();

    // start with FF during an active A5 transfer is ignored
    go(0, 8'hA5);
    repeat (9) tick();
    start4 = 1'b1; data4 = 8'hFF;
    tick();
    start4 = 1'b0;
    wait_done(0, 11, cyc, bc);
    check("t4_done_cycle", cyc, 65);
    check("t4_rd", rd4, 8'hA5);
    dones = 0;
    repeat (80) begin
      tick();
      if (done4 === 1'b1) dones++;
    end
    check("t4_single_done", dones, 0);

    // Back-to-back: start on the done cycle
    go(0, 8'h11);
    wait_done(0, 1, cyc, bc);
    check("t5_first_done", cyc, 65);
    start4 = 1'b1; data4 = 8'h5A;
    tick();
    start4 = 1'b0;
    check("t5_sck_fell", sck4, 1'b0);
    check("t5_busy", busy4, 1'b1);
    wait_done(0, 1, cyc, bc);
    check("t5_second_done", cyc, 65);
    check("t5_rd", rd4, 8'h5A);
    tick();

    // H=1 single and back-to-back
    go(1, 8'hA5);
    wait_done(1, 1, cyc, bc);
    check("h1_done_cycle", cyc, 17);
    check("h1_busy_cycles", bc, 16);
    check("h1_rd", rd1, 8'hA5);
    start1 = 1'b1; data1 = 8'h5A;
    tick();
    start1 = 1'b0;
    check("h1_sck_fell", sck1, 1'b0);
    wait_done(1, 1, cyc, bc);
    check("h1_second_done", cyc, 17);
    check("h1_rd2", rd1, 8'h5A);
    tick();

    // Reset at cycle 20 of a transfer, then a fresh 81 transfer
    go(0, 8'h33);
    repeat (19) tick();
    res4 = 1'b1;
    slave_reset();
    tick();
    res4 = 1'b0;
    check("t6_sck", sck4, 1'b1);
    check("t6_busy", busy4, 1'b0);
    check("t6_done", done4, 1'b0);
    dones = 0;
    repeat (70) begin
      tick();
      if (done4 === 1'b1) dones++;
    end
    check("t6_no_done", dones, 0);
    go(0, 8'h81);
    wait_done(0, 1, cyc, bc);
    check("t6_done_cycle", cyc, 65);
    check("t6_rd", rd4, 8'h81);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
